// File: rtl/lb2spi_master.sv
// Local-bus to SPI mode-0 master bridge: serialises one register write or read per frame
// as {address, mode, strobe byte, data}, MSB first, and returns read data from MISO.
module lb2spi_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned STRB_W  = DATA_W / 8,
  parameter int unsigned SCK_DIV = 8,
  parameter int unsigned CS_GAP  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lb_waddr,
  input  logic [DATA_W-1:0] lb_wdata,
  input  logic [STRB_W-1:0] lb_wstrb,
  input  logic              lb_wen,
  output logic              lb_wready,
  input  logic [ADDR_W-1:0] lb_raddr,
  input  logic              lb_ren,
  output logic [DATA_W-1:0] lb_rdata,
  output logic              lb_rvalid,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int unsigned FRAME_W = ADDR_W + 8 + DATA_W;
  localparam int unsigned BIT_W   = $clog2(FRAME_W) + 1;
  localparam int unsigned DIV_MAX = (SCK_DIV > CS_GAP) ? SCK_DIV : CS_GAP;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, LO, HI, HOLD, GAP} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [FRAME_W-1:0] shreg, sh_nxt;
  logic [DATA_W-1:0]  cap, cap_nxt;
  logic               is_wr, wr_nxt;
  logic               cs_nxt, sck_nxt, mosi_nxt, busy_nxt;
  logic               wready_nxt, rvalid_nxt;
  logic [DATA_W-1:0]  rdata_nxt;
  logic [1:0]         miso_sync;
  logic [7:0]         wctrl;
  logic [FRAME_W-1:0] wframe, rframe;
  logic               div_done;

  assign wctrl    = 8'h80 | 8'(lb_wstrb);
  assign wframe   = {lb_waddr, wctrl, lb_wdata};
  assign rframe   = {lb_raddr, 8'h00, {DATA_W{1'b0}}};
  assign div_done = (div_cnt == '0);

  // Next-state and next-output logic
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    bit_nxt    = bit_cnt;
    sh_nxt     = shreg;
    cap_nxt    = cap;
    wr_nxt     = is_wr;
    cs_nxt     = spi_cs_n;
    sck_nxt    = spi_sck;
    mosi_nxt   = spi_mosi;
    busy_nxt   = busy;
    rdata_nxt  = lb_rdata;
    wready_nxt = 1'b0;
    rvalid_nxt = 1'b0;
    if (!div_done) div_nxt = div_cnt - DIV_W'(1);

    unique case (state)
      IDLE: begin
        if (lb_wen || lb_ren) begin
          sh_nxt    = lb_wen ? wframe : rframe;
          wr_nxt    = lb_wen;
          mosi_nxt  = lb_wen ? wframe[FRAME_W-1] : rframe[FRAME_W-1];
          cs_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          div_nxt   = DIV_W'(SCK_DIV - 1);
          bit_nxt   = BIT_W'(FRAME_W - 1);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (div_done) begin
          div_nxt   = DIV_W'(SCK_DIV - 1);
          state_nxt = LO;
        end
      end
      LO: begin
        if (div_done) begin
          sck_nxt   = 1'b1;
          div_nxt   = DIV_W'(SCK_DIV - 1);
          state_nxt = HI;
          // Read data occupies the last DATA_W bits; sample on the rising-edge cycle
          if (!is_wr && (bit_cnt < BIT_W'(DATA_W)))
            cap_nxt = {cap[DATA_W-2:0], miso_sync[1]};
        end
      end
      HI: begin
        if (div_done) begin
          sck_nxt = 1'b0;
          div_nxt = DIV_W'(SCK_DIV - 1);
          if (bit_cnt != '0) begin
            sh_nxt    = {shreg[FRAME_W-2:0], 1'b0};
            mosi_nxt  = shreg[FRAME_W-2];
            bit_nxt   = bit_cnt - BIT_W'(1);
            state_nxt = LO;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (div_done) begin
          cs_nxt   = 1'b1;
          mosi_nxt = 1'b0;
          div_nxt  = DIV_W'(CS_GAP - 1);
          if (is_wr) begin
            wready_nxt = 1'b1;
          end else begin
            rdata_nxt  = cap;
            rvalid_nxt = 1'b1;
          end
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (div_done) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      cap       <= '0;
      is_wr     <= 1'b0;
      miso_sync <= '0;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      busy      <= 1'b0;
      lb_wready <= 1'b0;
      lb_rvalid <= 1'b0;
      lb_rdata  <= '0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      shreg     <= sh_nxt;
      cap       <= cap_nxt;
      is_wr     <= wr_nxt;
      miso_sync <= {miso_sync[0], spi_miso};
      spi_cs_n  <= cs_nxt;
      spi_sck   <= sck_nxt;
      spi_mosi  <= mosi_nxt;
      busy      <= busy_nxt;
      lb_wready <= wready_nxt;
      lb_rvalid <= rvalid_nxt;
      lb_rdata  <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_lb2spi_master.sv
// Bench for lb2spi_master: SPI slave register-map model plus frame and response scoreboards.
module tb_lb2spi_master;

  localparam int unsigned CS_GAP  = 8;
  localparam int          LATENCY = 8 * (2 * 32 + 2);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lb_waddr = '0;
  logic [15:0] lb_wdata = '0;
  logic [1:0]  lb_wstrb = '0;
  logic        lb_wen = 1'b0;
  logic        lb_wready;
  logic [7:0]  lb_raddr = '0;
  logic        lb_ren = 1'b0;
  logic [15:0] lb_rdata;
  logic        lb_rvalid;
  logic        busy;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso = 1'b0;

  lb2spi_master #(.ADDR_W(8), .DATA_W(16), .STRB_W(2), .SCK_DIV(8), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
    .lb_wready(lb_wready),
    .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid),
    .busy(busy), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] bits; int nbits; } frame_t;
  typedef struct { bit is_wr; logic [15:0] rdata; } resp_t;

  frame_t fq[$];
  resp_t  rq[$];
  int checks = 0;
  int errors = 0;
  int spi_nbits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // SPI slave model: samples MOSI on sck rise, drives MISO on sck fall, owns a register map
  initial begin : slave
    logic [15:0] regmap [256];
    logic [31:0] rx;
    logic [15:0] rd_word;
    logic        prev_sck, prev_cs, prev_mosi;
    bit          glitch, seen_frame;
    int          gap_cnt, idx;
    frame_t      e;
    for (int i = 0; i < 256; i++) regmap[i] = '0;
    regmap[8'h3C] = 16'hBEEF;
    rx = '0; rd_word = '0; prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    glitch = 0; seen_frame = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (spi_cs_n === 1'b0 && prev_cs === 1'b1) begin
        if (seen_frame) check("cs_gap_min", 32'(gap_cnt >= int'(CS_GAP)), 32'd1);
        spi_nbits = 0; rx = '0; glitch = 0; spi_miso = 1'b0;
      end
      if (spi_cs_n === 1'b0) begin
        if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
          rx = {rx[30:0], spi_mosi};
          spi_nbits++;
          if (spi_nbits == 8) rd_word = regmap[rx[7:0]];
        end
        if (spi_sck === 1'b1 && prev_sck === 1'b1 && spi_mosi !== prev_mosi) glitch = 1;
        if (spi_sck === 1'b0 && prev_sck === 1'b1) begin
          idx = 31 - spi_nbits;
          spi_miso = (spi_nbits >= 16 && spi_nbits < 32) ? rd_word[idx[3:0]] : 1'b0;
        end
      end
      if (spi_cs_n === 1'b1 && prev_cs === 1'b0) begin
        if (fq.size() == 0) begin
          check("unexpected_frame", 32'(spi_nbits), 32'd0);
        end else begin
          e = fq.pop_front();
          check("frame_bits", 32'(spi_nbits), 32'(e.nbits));
          if (e.nbits == 32) begin
            check("frame_mosi", rx, e.bits);
            check("mosi_stable_sck_hi", 32'(glitch), 32'd0);
            if (rx[23]) begin
              if (rx[16]) regmap[rx[31:24]][7:0]  = rx[7:0];
              if (rx[17]) regmap[rx[31:24]][15:8] = rx[15:8];
            end
          end
        end
        gap_cnt = 0;
        seen_frame = 1;
        spi_miso = 1'b0;
      end
      if (spi_cs_n === 1'b1) gap_cnt++;
      prev_sck = spi_sck; prev_cs = spi_cs_n; prev_mosi = spi_mosi;
    end
  end

  // Response monitor: every wready/rvalid pulse is matched against the expected queue
  initial begin : resp_mon
    int     cyc, start;
    logic   prev_busy;
    resp_t  e;
    cyc = 0; start = 0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && prev_busy !== 1'b1) start = cyc;
      if (lb_wready === 1'b1 || lb_rvalid === 1'b1) begin
        if (rq.size() == 0) begin
          check("unexpected_resp", {30'd0, lb_wready, lb_rvalid}, 32'd0);
        end else begin
          e = rq.pop_front();
          check("resp_kind", {30'd0, lb_wready, lb_rvalid}, e.is_wr ? 32'd2 : 32'd1);
          if (!e.is_wr) check("rdata", 32'(lb_rdata), 32'(e.rdata));
          check("resp_latency", 32'(cyc - start), 32'(LATENCY));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic wait_resp(input bit wr, input string name);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(wr ? lb_wready : lb_rvalid) && n < 3000);
    check(name, 32'(n < 3000), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s,
                          input logic [31:0] exp_frame);
    fq.push_back('{exp_frame, 32});
    rq.push_back('{1'b1, 16'h0});
    lb_waddr = a; lb_wdata = d; lb_wstrb = s; lb_wen = 1'b1;
    wait_resp(1'b1, "write_timeout");
    lb_wen = 1'b0;
    idle(20);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_frame,
                         input logic [15:0] exp_data);
    fq.push_back('{exp_frame, 32});
    rq.push_back('{1'b0, exp_data});
    lb_raddr = a; lb_ren = 1'b1;
    wait_resp(1'b0, "read_timeout");
    lb_ren = 1'b0;
    idle(20);
  endtask

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n",   32'(spi_cs_n),  32'd1);
    check("rst_sck",    32'(spi_sck),   32'd0);
    check("rst_mosi",   32'(spi_mosi),  32'd0);
    check("rst_wready", 32'(lb_wready), 32'd0);
    check("rst_rvalid", 32'(lb_rvalid), 32'd0);
    check("rst_rdata",  32'(lb_rdata),  32'd0);
    check("rst_busy",   32'(busy),      32'd0);
    rst = 1'b0;
    idle(5);

    do_write(8'h12, 16'hA5C3, 2'b11, 32'h1283_A5C3);
    do_read(8'h3C, 32'h3C00_0000, 16'hBEEF);
    idle(30);
    check("rdata_hold", 32'(lb_rdata), 32'h0000_BEEF);

    do_write(8'h20, 16'h1111, 2'b01, 32'h2081_1111);
    do_write(8'h21, 16'h2222, 2'b10, 32'h2182_2222);

    // Simultaneous requests: write wins, read follows after the gap
    fq.push_back('{32'h3083_0F0F, 32});
    fq.push_back('{32'h3000_0000, 32});
    rq.push_back('{1'b1, 16'h0});
    rq.push_back('{1'b0, 16'h0F0F});
    lb_waddr = 8'h30; lb_wdata = 16'h0F0F; lb_wstrb = 2'b11; lb_raddr = 8'h30;
    lb_wen = 1'b1; lb_ren = 1'b1;
    wait_resp(1'b1, "both_write_timeout");
    lb_wen = 1'b0;
    wait_resp(1'b0, "both_read_timeout");
    lb_ren = 1'b0;
    idle(20);

    // Reset in the middle of a write frame
    fq.push_back('{32'h0, 10});
    lb_waddr = 8'h55; lb_wdata = 16'h1234; lb_wstrb = 2'b11; lb_wen = 1'b1;
    n = 0;
    while (!(spi_cs_n === 1'b0 && spi_nbits == 10) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("bit10_timeout", 32'(n < 3000), 32'd1);
    rst = 1'b1; lb_wen = 1'b0;
    @(posedge clk); #1;
    check("midrst_cs_n",  32'(spi_cs_n), 32'd1);
    check("midrst_sck",   32'(spi_sck),  32'd0);
    check("midrst_busy",  32'(busy),     32'd0);
    check("midrst_rdata", 32'(lb_rdata), 32'd0);
    rst = 1'b0;
    idle(40);
    do_write(8'h66, 16'h7777, 2'b11, 32'h6683_7777);

    // Write then read back through the slave register map
    do_write(8'h04, 16'h5A5A, 2'b11, 32'h0483_5A5A);
    do_read(8'h04, 32'h0400_0000, 16'h5A5A);

    idle(50);
    check("frames_pending", 32'(fq.size()), 32'd0);
    check("resps_pending",  32'(rq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
